// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and forwarding controller for the pipelined RISC-V core. It keeps a
//   shadow copy of the instructions in E..W. From that copy it drives the
//   forwarding selects, the load-use stall and bubble, the branch/jump flush
//   and the global memory freeze. It also keeps saturating stall and flush
//   counters.
// Ports
//   clk, rst           core clock, asynchronous active-low reset
//   valid_d .. is_load_d  decode-stage instruction fields
//   pc_src_e           branch taken / jump resolved in E
//   mem_stall          data memory busy, freezes everything
//   stall_f, stall_d   hold PC / F-D register
//   flush_d, flush_e   clear F-D / D-E register
//   fwd_a_e, fwd_b_e   ALU operand source: 0 = regfile, k = shadow entry k
//   stall_count        load-use stall cycles (saturating)
//   flush_count        control flush events (saturating)

// Per-stage producer match. This is instantiated once for each older stage k >= 1.
module phc_stage_match #(
  parameter int AW = 5
) (
  input  logic          v0,
  input  logic          vk,
  input  logic          rwk,
  input  logic [AW-1:0] rdk,
  input  logic [AW-1:0] rs1_0,
  input  logic [AW-1:0] rs2_0,
  output logic          hit_a,
  output logic          hit_b
);
  logic prod;
  // x0 is hardwired zero, so a write to it is never a forwarding source.
  assign prod  = v0 & vk & rwk & (rdk != '0);
  assign hit_a = prod & (rdk == rs1_0);
  assign hit_b = prod & (rdk == rs2_0);
endmodule

module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int STAGES         = 3,
  parameter int FWD_SEL_WIDTH  = $clog2(STAGES),
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      reg_write_d,
  input  logic                      is_load_d,
  input  logic                      pc_src_e,
  input  logic                      mem_stall,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [FWD_SEL_WIDTH-1:0]  fwd_a_e,
  output logic [FWD_SEL_WIDTH-1:0]  fwd_b_e,
  output logic [COUNT_WIDTH-1:0]    stall_count,
  output logic [COUNT_WIDTH-1:0]    flush_count
);
  localparam int AW = REG_ADDR_WIDTH;

  // Shadow pipeline, entry 0 = E. The source indices and the load flag only
  // matter while an instruction sits in E. Older stages shift only v/rd/rw.
  logic [STAGES-1:0]         sh_v, sh_rw;
  logic [STAGES-1:0][AW-1:0] sh_rd;
  logic [AW-1:0]             rs1_e, rs2_e;
  logic                      ld_e;

  logic                      lu, ctrl;
  logic [STAGES-1:0]         hit_a, hit_b;

  assign hit_a[0] = 1'b0;
  assign hit_b[0] = 1'b0;

  genvar k;
  generate
    for (k = 1; k < STAGES; k++) begin : g_match
      phc_stage_match #(.AW(AW)) u_match (
        .v0    (sh_v[0]),
        .vk    (sh_v[k]),
        .rwk   (sh_rw[k]),
        .rdk   (sh_rd[k]),
        .rs1_0 (rs1_e),
        .rs2_0 (rs2_e),
        .hit_a (hit_a[k]),
        .hit_b (hit_b[k])
      );
    end
  endgenerate

  // Priority encode with the youngest stage winning. The scan goes from oldest to youngest so
  // that the last assignment made is the lowest k.
  always_comb begin
    fwd_a_e = '0;
    fwd_b_e = '0;
    for (int i = STAGES - 1; i >= 1; i--) begin
      if (hit_a[i]) fwd_a_e = FWD_SEL_WIDTH'(i);
      if (hit_b[i]) fwd_b_e = FWD_SEL_WIDTH'(i);
    end
  end

  assign lu   = sh_v[0] & ld_e & sh_rw[0] & (sh_rd[0] != '0) & valid_d &
                ((sh_rd[0] == rs1_d) | (sh_rd[0] == rs2_d));
  assign ctrl = pc_src_e & sh_v[0];

  // The memory freeze masks everything. A control flush overrides the load-use stall. The
  // load-use fetch would be redirected anyway.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else begin
      flush_d = ctrl;
      flush_e = ctrl | lu;
      stall_f = lu & ~ctrl;
      stall_d = lu & ~ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_v  <= '0;
      sh_rw <= '0;
      sh_rd <= '0;
      rs1_e <= '0;
      rs2_e <= '0;
      ld_e  <= 1'b0;
    end else if (!mem_stall) begin
      for (int i = 1; i < STAGES; i++) begin
        sh_v[i]  <= sh_v[i-1];
        sh_rw[i] <= sh_rw[i-1];
        sh_rd[i] <= sh_rd[i-1];
      end
      if (flush_e) begin
        sh_v[0]  <= 1'b0;
        sh_rw[0] <= 1'b0;
        sh_rd[0] <= '0;
        rs1_e    <= '0;
        rs2_e    <= '0;
        ld_e     <= 1'b0;
      end else begin
        sh_v[0]  <= valid_d;
        sh_rw[0] <= reg_write_d;
        sh_rd[0] <= rd_d;
        rs1_e    <= rs1_d;
        rs2_e    <= rs2_d;
        ld_e     <= is_load_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (!mem_stall) begin
      if (ctrl) begin
        if (flush_count != '1) flush_count <= flush_count + 1'b1;
      end else if (lu) begin
        if (stall_count != '1) stall_count <= stall_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int S    = 3;
  localparam int AW   = 5;
  localparam int FW   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          valid_d, reg_write_d, is_load_d, pc_src_e, mem_stall;
  logic [AW-1:0] rs1_d, rs2_d, rd_d;
  logic          stall_f, stall_d, flush_d, flush_e;
  logic [FW-1:0] fwd_a_e, fwd_b_e;
  logic [CW-1:0] stall_count, flush_count;

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .STAGES(S), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rd_d(rd_d), .reg_write_d(reg_write_d), .is_load_d(is_load_d),
    .pc_src_e(pc_src_e), .mem_stall(mem_stall), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  // Reference model: a queue of instructions, where the front is E.
  typedef struct {bit v; int rd; int rs1; int rs2; bit rw; bit ld;} ins_t;
  typedef struct {bit sf; bit sd; bit fd; bit fe; int fa; int fb; int sc; int fc;} exp_t;

  ins_t pipe[$];
  exp_t sb[$];
  ins_t d_in;
  bit   pc_in, ms_in;
  int   sc_m, fc_m;
  int   n_chk = 0, n_fail = 0;

  function automatic void clear_model();
    ins_t b;
    b = '{v:0, rd:0, rs1:0, rs2:0, rw:0, ld:0};
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back(b);
    sc_m = 0;
    fc_m = 0;
  endfunction

  function automatic int fwd_src(int rs);
    if (!pipe[0].v) return 0;
    for (int i = 1; i < S; i++)
      if (pipe[i].v && pipe[i].rw && pipe[i].rd != 0 && pipe[i].rd == rs) return i;
    return 0;
  endfunction

  function automatic bit lu_m();
    return pipe[0].v && pipe[0].ld && pipe[0].rw && pipe[0].rd != 0 && d_in.v &&
           (pipe[0].rd == d_in.rs1 || pipe[0].rd == d_in.rs2);
  endfunction

  function automatic bit ctrl_m();
    return pc_in && pipe[0].v;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit lu, c;
    lu = lu_m();
    c  = ctrl_m();
    if (ms_in) begin
      e.sf = 1; e.sd = 1; e.fd = 0; e.fe = 0;
    end else begin
      e.fd = c; e.fe = c || lu; e.sf = lu && !c; e.sd = lu && !c;
    end
    e.fa = fwd_src(pipe[0].rs1);
    e.fb = fwd_src(pipe[0].rs2);
    e.sc = sc_m;
    e.fc = fc_m;
    return e;
  endfunction

  // Models the rising edge for the inputs that were applied during the cycle that is ending.
  function automatic void advance();
    bit lu, c;
    ins_t b;
    b  = '{v:0, rd:0, rs1:0, rs2:0, rw:0, ld:0};
    lu = lu_m();
    c  = ctrl_m();
    if (ms_in) return;
    if (c) fc_m = (fc_m < CMAX) ? fc_m + 1 : CMAX;
    else if (lu) sc_m = (sc_m < CMAX) ? sc_m + 1 : CMAX;
    void'(pipe.pop_back());
    pipe.push_front((c || lu) ? b : d_in);
  endfunction

  task automatic cyc(input bit r, input bit v, input int rd, input int rs1, input int rs2,
                     input bit rw, input bit ld, input bit pc, input bit ms);
    @(posedge clk);
    if (rst) advance();
    #1;
    rst = r;
    if (!r) clear_model();
    valid_d = v; rd_d = AW'(rd); rs1_d = AW'(rs1); rs2_d = AW'(rs2);
    reg_write_d = rw; is_load_d = ld; pc_src_e = pc; mem_stall = ms;
    d_in  = '{v:v, rd:rd, rs1:rs1, rs2:rs2, rw:rw, ld:ld};
    pc_in = pc;
    ms_in = ms;
    sb.push_back(expect_now());
  endtask

  task automatic alu(input int rd, input int rs1, input int rs2, input bit ms = 0);
    cyc(1, 1, rd, rs1, rs2, 1, 0, 0, ms);
  endtask
  task automatic lw(input int rd, input int rs1);
    cyc(1, 1, rd, rs1, 0, 1, 1, 0, 0);
  endtask
  task automatic nop();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per falling edge.
  exp_t me;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("stall_f", int'(stall_f), int'(me.sf));
      chk("stall_d", int'(stall_d), int'(me.sd));
      chk("flush_d", int'(flush_d), int'(me.fd));
      chk("flush_e", int'(flush_e), int'(me.fe));
      chk("fwd_a_e", int'(fwd_a_e), me.fa);
      chk("fwd_b_e", int'(fwd_b_e), me.fb);
      chk("stall_count", int'(stall_count), me.sc);
      chk("flush_count", int'(flush_count), me.fc);
    end
  end

  initial begin
    valid_d = 0; rd_d = '0; rs1_d = '0; rs2_d = '0; reg_write_d = 0;
    is_load_d = 0; pc_src_e = 0; mem_stall = 0;
    d_in = '{v:0, rd:0, rs1:0, rs2:0, rw:0, ld:0};
    pc_in = 0; ms_in = 0;
    clear_model();
    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);          // reset state
    nop();
    // ALU chain, including an x0 producer.
    alu(5, 1, 2); alu(6, 5, 1); alu(7, 5, 2); nop();
    alu(0, 1, 2); alu(3, 0, 0); nop(); nop();
    // Double hit: x5 written twice, with the youngest winning.
    alu(5, 1, 1); alu(5, 2, 2); alu(9, 3, 5); nop(); nop();
    // Load-use, with the consumer held in D while stalled.
    lw(8, 1); alu(9, 8, 3); alu(9, 8, 3); alu(10, 9, 8); nop(); nop();
    // Branch over load-use.
    lw(8, 1); cyc(1, 1, 9, 8, 3, 1, 0, 1, 0); nop(); nop();
    // Memory freeze in the middle of an ALU chain.
    alu(5, 1, 2); alu(6, 5, 1);
    alu(7, 5, 2, 1); alu(7, 5, 2, 1); alu(7, 5, 2, 1);
    alu(7, 5, 2); alu(11, 7, 6); nop(); nop();
    // Reset pulse with the pipeline full.
    alu(5, 1, 2); alu(6, 5, 5); alu(7, 6, 5);
    cyc(0, 1, 4, 4, 4, 1, 0, 0, 0);
    nop(); nop();
    // 20 load-use events drive stall_count into saturation.
    for (int i = 0; i < 20; i++) begin
      lw(8, 1);
      alu(9, 3, 8);
    end
    nop();
    // Random traffic over a small register range so that hits are frequent.
    for (int i = 0; i < 2000; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
